// File: rtl/ts19a64_pkg.sv
// ---------------------------------------------------------------------------
// ts19a64_pkg
//   Shared definitions for the TS19A64 front end: machine widths, the bubble
//   encoding driven onto Inst when nothing valid is presented, opcode field
//   constants used to assemble test programs, the fetch-unit state encoding
//   and a small helper that decides whether a PC lies inside instruction
//   memory.
// ---------------------------------------------------------------------------
package ts19a64_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] INST_BUBBLE = 32'h0000_0000;

  // Opcode fields (most-significant bits of the instruction word)
  localparam logic [9:0]  ADDI = 10'b1001000100;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [5:0]  B    = 6'b000101;
  localparam logic [7:0]  CBZ  = 8'b10110100;

  // The fetch unit is either streaming instructions or parked after an
  // out-of-range fetch; only reset leaves the fault state.
  typedef enum logic {
    FS_RUN   = 1'b0,
    FS_FAULT = 1'b1
  } fetch_state_e;

  // A byte PC is fetchable when every bit above the word index is zero.
  function automatic logic pc_in_range(input logic [XLEN-1:0] pc,
                                       input int              aw);
    return ((pc >> (aw + 2)) == '0);
  endfunction

endpackage

// File: rtl/ts19a64_imem.sv
// ---------------------------------------------------------------------------
// ts19a64_imem
//   Word-addressed instruction RAM: one synchronous read port and one
//   write port. Contents are never reset.
//
// Ports:
//   clk      rising-edge clock
//   rd_en    capture mem[rd_addr] into rd_data at the edge; hold otherwise
//   rd_addr  word address to read
//   rd_data  registered read data
//   wr_en    write wr_data into mem[wr_addr] at the edge
//   wr_addr  word address to write
//   wr_data  word to store
// ---------------------------------------------------------------------------
module ts19a64_imem
  import ts19a64_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic            clk,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [ILEN-1:0] rd_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [ILEN-1:0] wr_data
);

  logic [ILEN-1:0] mem_q [DEPTH];
  logic [ILEN-1:0] rd_data_q;

  // Both ports use non-blocking updates in one block, so a read of the
  // address being written on the same edge returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ts19a64_fetch_unit.sv
// ---------------------------------------------------------------------------
// ts19a64_fetch_unit
//   Instruction fetch stage feeding the TS19A64 datapath. Holds the 64-bit
//   PC and an instruction RAM, presents one registered instruction per cycle
//   with a valid flag, and supports stall, PC-relative branch redirect with
//   a one-slot flush, a program-load port and a sticky out-of-range fault.
//
// Ports:
//   CLK        rising-edge clock
//   Reset      asynchronous active-low reset
//   Stall      hold PC and the presented instruction this cycle
//   Branch     redirect relative to InstPC (only honoured while InstValid)
//   BrOffset   signed word offset, already sign-extended
//   LoadEn     write LoadData to memory at LoadAddr
//   LoadAddr   word address for the load
//   LoadData   instruction word to store
//   Inst       fetched instruction (bubble encoding when not valid)
//   InstValid  Inst is a real instruction
//   InstPC     byte address of Inst
//   PC         byte address of the next fetch
//   Fault      sticky out-of-range fetch flag
// ---------------------------------------------------------------------------
module ts19a64_fetch_unit
  import ts19a64_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Stall,
  input  logic            Branch,
  input  logic [XLEN-1:0] BrOffset,
  input  logic            LoadEn,
  input  logic [AW-1:0]   LoadAddr,
  input  logic [ILEN-1:0] LoadData,
  output logic [ILEN-1:0] Inst,
  output logic            InstValid,
  output logic [XLEN-1:0] InstPC,
  output logic [XLEN-1:0] PC,
  output logic            Fault
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_valid_q, inst_valid_d;

  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [ILEN-1:0] rd_data;

  // Word index of the next fetch; PC[1:0] is always zero.
  assign rd_addr = pc_q[AW+1:2];

  ts19a64_imem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk     (CLK),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (LoadEn),
    .wr_addr (LoadAddr),
    .wr_data (LoadData)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= FS_RUN;
      pc_q         <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Branch outranks Stall but is only meaningful for a valid instruction.
  // A fetch edge either reads the RAM and advances the PC, or, if the PC
  // has left memory, parks the unit in the fault state with the PC frozen.
  // The RAM read register is only enabled on real fetches, so a stall keeps
  // the presented word in place without any extra instruction register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    rd_en        = 1'b0;

    if (state_q == FS_RUN) begin
      if (Branch && inst_valid_q) begin
        pc_d         = inst_pc_q + (BrOffset << 2);
        inst_valid_d = 1'b0;
      end else if (!Stall) begin
        if (!pc_in_range(pc_q, AW)) begin
          state_d      = FS_FAULT;
          inst_valid_d = 1'b0;
        end else begin
          rd_en        = 1'b1;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_q + 64'd4;
        end
      end
    end else begin
      inst_valid_d = 1'b0;
    end
  end

  // The RAM output is gated so the datapath sees the bubble whenever the
  // slot is flushed, faulted or still empty after reset.
  assign Inst      = inst_valid_q ? rd_data : INST_BUBBLE;
  assign InstValid = inst_valid_q;
  assign InstPC    = inst_pc_q;
  assign PC        = pc_q;
  assign Fault     = (state_q == FS_FAULT);

endmodule

// File: tb/tb_ts19a64_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ts19a64_fetch_unit
//   Directed bench for the fetch unit built with a 16-word memory. Each
//   stimulus cycle pushes its hand-computed expected outputs into a queue;
//   a monitor pops one entry after every rising edge and compares it with
//   what the unit presents.
// ---------------------------------------------------------------------------
module tb_ts19a64_fetch_unit;
  import ts19a64_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct {
    int          id;
    logic [31:0] inst;
    logic        valid;
    logic [63:0] instPC;
    logic [63:0] pc;
    logic        fault;
  } exp_t;

  logic        CLK;
  logic        Reset;
  logic        Stall;
  logic        Branch;
  logic [63:0] BrOffset;
  logic        LoadEn;
  logic [3:0]  LoadAddr;
  logic [31:0] LoadData;
  logic [31:0] Inst;
  logic        InstValid;
  logic [63:0] InstPC;
  logic [63:0] PC;
  logic        Fault;

  exp_t sbQueue[$];
  int   vecCount  = 0;
  int   missCount = 0;
  int   nextId    = 0;

  ts19a64_fetch_unit #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Stall     (Stall),
    .Branch    (Branch),
    .BrOffset  (BrOffset),
    .LoadEn    (LoadEn),
    .LoadAddr  (LoadAddr),
    .LoadData  (LoadData),
    .Inst      (Inst),
    .InstValid (InstValid),
    .InstPC    (InstPC),
    .PC        (PC),
    .Fault     (Fault)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Compare present outputs against one expectation; InstPC is only
  // defined while the slot holds a valid instruction.
  task automatic checkOutput(input exp_t e);
    logic bad;
    bad = (Inst !== e.inst) || (InstValid !== e.valid) || (PC !== e.pc) ||
          (Fault !== e.fault) || (e.valid && (InstPC !== e.instPC));
    vecCount++;
    if (bad) begin
      missCount++;
      $display("[TB] FAIL vec%0d: got inst=%h valid=%b instpc=%h pc=%h fault=%b, expected inst=%h valid=%b instpc=%h pc=%h fault=%b",
               e.id, Inst, InstValid, InstPC, PC, Fault,
               e.inst, e.valid, e.instPC, e.pc, e.fault);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the
  // outputs must look like after the following rising edge.
  task automatic applyStimulus(input logic rstN, input logic stall,
                               input logic br, input logic [63:0] off,
                               input logic le, input logic [3:0] la,
                               input logic [31:0] ld,
                               input logic [31:0] eInst, input logic eValid,
                               input logic [63:0] eInstPC,
                               input logic [63:0] ePC, input logic eFault);
    exp_t e;
    @(negedge CLK);
    Reset    = rstN;
    Stall    = stall;
    Branch   = br;
    BrOffset = off;
    LoadEn   = le;
    LoadAddr = la;
    LoadData = ld;
    e.id     = nextId;
    e.inst   = eInst;
    e.valid  = eValid;
    e.instPC = eInstPC;
    e.pc     = ePC;
    e.fault  = eFault;
    nextId++;
    sbQueue.push_back(e);
  endtask

  // Monitor: one expectation is consumed per rising edge.
  always @(posedge CLK) begin
    #1;
    if (sbQueue.size() > 0) begin
      checkOutput(sbQueue.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t        z;
    logic [31:0] wAddi, wStur, wLdur, wCbz, wB;
    logic [63:0] none;

    // ADDI X1,X0,#5 / STUR X1,[X31,#1] / LDUR X2,[X31,#1] / CBZ X0,#2 / B #2
    wAddi = {ADDI, 12'd5, 5'd0, 5'd1};
    wStur = {STUR, 9'd1, 2'b00, 5'd31, 5'd1};
    wLdur = {LDUR, 9'd1, 2'b00, 5'd31, 5'd2};
    wCbz  = {CBZ, 19'd2, 5'd0};
    wB    = {B, 26'd2};
    none  = 64'd0;

    Reset    = 1'b0;
    Stall    = 1'b0;
    Branch   = 1'b0;
    BrOffset = '0;
    LoadEn   = 1'b0;
    LoadAddr = '0;
    LoadData = '0;

    z.id = -1; z.inst = 32'h0; z.valid = 1'b0; z.instPC = 64'd0;
    z.pc = 64'd0; z.fault = 1'b0;
    #1;
    checkOutput(z);

    // Program load while held in reset
    applyStimulus(0,0,0,none, 1,4'd0,wAddi, 32'h0,0,64'd0,64'd0,0);
    applyStimulus(0,0,0,none, 1,4'd1,wStur, 32'h0,0,64'd0,64'd0,0);
    applyStimulus(0,0,0,none, 1,4'd2,wLdur, 32'h0,0,64'd0,64'd0,0);
    applyStimulus(0,0,0,none, 1,4'd3,wCbz,  32'h0,0,64'd0,64'd0,0);

    // Release reset, stream, stall three cycles on STUR, resume
    applyStimulus(1,0,0,none, 0,4'd0,32'h0, 32'h91001401,1,64'd0,64'd4,0);
    applyStimulus(1,0,0,none, 0,4'd0,32'h0, 32'hF80013E1,1,64'd4,64'd8,0);
    applyStimulus(1,1,0,none, 0,4'd0,32'h0, 32'hF80013E1,1,64'd4,64'd8,0);
    applyStimulus(1,1,0,none, 0,4'd0,32'h0, 32'hF80013E1,1,64'd4,64'd8,0);
    applyStimulus(1,1,0,none, 0,4'd0,32'h0, 32'hF80013E1,1,64'd4,64'd8,0);
    applyStimulus(1,0,0,none, 0,4'd0,32'h0, 32'hF84013E2,1,64'd8,64'd12,0);

    // Branch -2 words from InstPC=8 -> PC 0, bubble; a Branch during the
    // bubble is ignored and word 0 is fetched
    applyStimulus(1,0,1,64'hFFFF_FFFF_FFFF_FFFE, 0,4'd0,32'h0, 32'h0,0,64'd0,64'd0,0);
    applyStimulus(1,0,1,64'd5, 0,4'd0,32'h0, 32'h91001401,1,64'd0,64'd4,0);

    // Branch +3 while stalled at InstPC=0 -> PC 12, then fetch word 3
    applyStimulus(1,1,1,64'd3, 0,4'd0,32'h0, 32'h0,0,64'd0,64'd12,0);
    applyStimulus(1,0,0,none, 0,4'd0,32'h0, 32'hB4000040,1,64'd12,64'd16,0);

    // Back to 0, then overwrite word 1 on the edge that fetches it
    applyStimulus(1,0,1,64'hFFFF_FFFF_FFFF_FFFD, 0,4'd0,32'h0, 32'h0,0,64'd0,64'd0,0);
    applyStimulus(1,0,0,none, 0,4'd0,32'h0, 32'h91001401,1,64'd0,64'd4,0);
    applyStimulus(1,0,0,none, 1,4'd1,32'hDEADBEEF, 32'hF80013E1,1,64'd4,64'd8,0);
    applyStimulus(1,0,1,64'hFFFF_FFFF_FFFF_FFFF, 0,4'd0,32'h0, 32'h0,0,64'd0,64'd0,0);
    applyStimulus(1,0,0,none, 0,4'd0,32'h0, 32'h91001401,1,64'd0,64'd4,0);
    applyStimulus(1,0,0,none, 0,4'd0,32'h0, 32'hDEADBEEF,1,64'd4,64'd8,0);

    // Return to InstPC=0 and jump to word 16 (outside a 16-word memory)
    applyStimulus(1,0,1,64'hFFFF_FFFF_FFFF_FFFF, 0,4'd0,32'h0, 32'h0,0,64'd0,64'd0,0);
    applyStimulus(1,0,0,none, 0,4'd0,32'h0, 32'h91001401,1,64'd0,64'd4,0);
    applyStimulus(1,0,1,64'd16, 0,4'd0,32'h0, 32'h0,0,64'd0,64'd64,0);
    applyStimulus(1,0,0,none, 0,4'd0,32'h0, 32'h0,0,64'd0,64'd64,1);
    applyStimulus(1,0,0,none, 1,4'd2,wB, 32'h0,0,64'd0,64'd64,1);
    applyStimulus(1,0,1,64'hFFFF_FFFF_FFFF_FFF0, 0,4'd0,32'h0, 32'h0,0,64'd0,64'd64,1);

    // Asynchronous reset mid-cycle clears everything at once
    @(posedge CLK);
    #2;
    Reset = 1'b0;
    #1;
    z.id = -2;
    checkOutput(z);

    // Memory survives reset, including the load made while faulted
    applyStimulus(0,0,0,none, 0,4'd0,32'h0, 32'h0,0,64'd0,64'd0,0);
    applyStimulus(1,0,0,none, 0,4'd0,32'h0, 32'h91001401,1,64'd0,64'd4,0);
    applyStimulus(1,0,0,none, 0,4'd0,32'h0, 32'hDEADBEEF,1,64'd4,64'd8,0);
    applyStimulus(1,0,0,none, 0,4'd0,32'h0, 32'h14000002,1,64'd8,64'd12,0);

    for (int i = 0; i < 10 && sbQueue.size() > 0; i++) begin
      @(posedge CLK);
      #2;
    end
    if (sbQueue.size() != 0) begin
      missCount++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0",
               sbQueue.size());
    end
    if (vecCount != nextId + 2) begin
      missCount++;
      $display("[TB] FAIL count: got %0d checks, expected %0d",
               vecCount, nextId + 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/ts19a64_fetch_unit.md
Name: ts19a64_fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the TS19A64 datapath and drives its 32-bit Inst input.
- Holds the 64-bit program counter and a word-addressed instruction memory.
- Presents one registered instruction per cycle with a valid flag.
- Supports stall, PC-relative branch redirect with one-slot flush, a program-load port for benches, and an out-of-range fault.

Parameters:
- DEPTH, 256, number of 32-bit instruction words in memory (power of two, 16..4096).
- AW, 8, word-address width, equal to log2(DEPTH).

Ports:
- CLK  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- Stall  input  1  hold PC and Inst for this cycle.
- Branch  input  1  redirect request for the instruction currently on Inst.
- BrOffset  input  64  signed word offset, already sign-extended by the datapath.
- LoadEn  input  1  write LoadData into memory.
- LoadAddr  input  AW  word address for the load.
- LoadData  input  32  instruction word to store.
- Inst  output  32  fetched instruction; feeds TS19A64 Inst.
- InstValid  output  1  Inst is a real instruction to execute.
- InstPC  output  64  byte address of Inst.
- PC  output  64  byte address of the next fetch.
- Fault  output  1  sticky out-of-range fetch flag.

Behaviour:
- Reset low (asynchronous):
  - PC=0, InstPC=0, Inst=32'h0, InstValid=0, Fault=0.
  - Memory contents are not cleared.
- Fetch index is PC[AW+1:2]. The read is registered, so there is 1 cycle of latency from PC to Inst.
- Normal edge (Reset high, Stall=0, Branch=0, Fault=0):
  - Inst<=mem[PC idx], InstPC<=PC, InstValid<=1, PC<=PC+4.
- Stall=1, Branch=0: PC, Inst, InstPC and InstValid all hold.
- Branch=1 (takes priority over Stall):
  - PC <= InstPC + (BrOffset<<2), 64-bit modulo-2^64 arithmetic.
  - InstValid<=0 (flush), Inst<=0.
  - The next unstalled edge fetches the target.
  - Branch is sampled only when InstValid=1; it is ignored otherwise.
- Out of range: if PC[63:AW+2] is non-zero at a fetch edge:
  - Fault<=1, InstValid<=0, Inst<=0, PC holds.
  - Fault is sticky until Reset; no further fetches occur.
- PC+4 wrap from 64'hFFFF_FFFF_FFFF_FFFC goes to 0. This is normally pre-empted by Fault when DEPTH is small.
- Load port:
  - LoadEn=1 writes mem[LoadAddr]<=LoadData at the edge.
  - It is legal during Stall and Fault.
  - A fetch of the same address on the same edge returns the old word; the new word is visible from the next edge.
- Inst stays 32'h0 whenever InstValid=0. The datapath must gate register/memory writes on InstValid.
- PC[1:0] is always 00 by construction.

Decomposition:
- Shared package ts19a64_pkg holds:
  - XLEN=64, ILEN=32.
  - INST_BUBBLE=32'h0000_0000.
  - Opcode constants used by the bench: ADDI=10'b1001000100, STUR=11'b11111000000, LDUR=11'b11111000010, B=6'b000101, CBZ=8'b10110100.
- One sub-module, ts19a64_imem: a simple dual-port RAM with one synchronous read port and one write port, parameterised by DEPTH/AW.
- PC/next-PC logic lives in the top module.

Test Plan:
- Reset then program load:
  - Load mem[0]=32'h91001401 (ADDI X1,X0,5), mem[1]=32'hF80013E1 (STUR), mem[2]=32'hF84013E2 (LDUR).
  - Release Reset.
  - Expect the next three edges to give Inst=91001401/F80013E1/F84013E2 with InstPC=0/4/8, InstValid=1, and PC=12 after the third edge.
- Stall:
  - Assert Stall for 3 cycles while Inst=F80013E1.
  - Expect Inst, InstPC=4 and PC=8 to hold, then resume with F84013E2.
- Branch:
  - With InstPC=8, apply Branch=1 and BrOffset=-2.
  - Expect one bubble (InstValid=0, Inst=0), then PC=0 and Inst=91001401 on the following edge.
- Branch during Stall:
  - Branch=1, Stall=1, BrOffset=+3 at InstPC=0.
  - Expect the redirect to take effect (PC=12) with a bubble.
- Fault:
  - Use DEPTH=16 and jump to word 16 (InstPC=0, BrOffset=16).
  - Expect Fault=1, InstValid=0 and PC frozen at 64.
  - Reset low asynchronously mid-cycle: expect all outputs to clear immediately.
- Load/fetch collision:
  - Write mem[1]=32'hDEADBEEF on the edge that fetches word 1.
  - Expect the old word on Inst; re-fetch after a branch back returns DEADBEEF.
